// File: rtl/pakin.sv
// pakin: two-phase packet receiver; range-checks the address, buffers data, forwards it to a two-phase sink.
// Address range checking is built only when NS_PAKIN_ADDR_CHECK_EN is defined.
`ifndef NS_ADDRESS_SIZE
`define NS_ADDRESS_SIZE 6
`endif
`ifndef NS_DATA_SIZE
`define NS_DATA_SIZE 4
`endif
`ifndef NS_PACKET_SIZE
`define NS_PACKET_SIZE 10
`endif

// Purpose: accept packets on rcv0, queue data in a DEPTH-entry FIFO, emit on snd0.
// Latency: rcv0_req toggle to rcv0_ack toggle in 3 edges; FIFO head to snd0_req toggle in 1 edge.
// Backpressure: in-range packets stall unacked while the FIFO is full; rejects are always acked.
module pakin #(
    parameter int PSZ      = `NS_PACKET_SIZE,
    parameter int ASZ      = `NS_ADDRESS_SIZE,
    parameter int DSZ      = `NS_DATA_SIZE,
    parameter int MIN_ADDR = 0,
    parameter int MAX_ADDR = 55,
    parameter int DEPTH    = 4
) (
    input  logic           i_clk,
    input  logic           reset,
    output logic           ready,
    input  logic [PSZ-1:0] rcv0_pakio,
    input  logic           rcv0_req,
    output logic           rcv0_ack,
    output logic [DSZ-1:0] snd0_data,
    output logic           snd0_req,
    input  logic           snd0_ack,
    output logic           o_err,
    output logic [ASZ-1:0] fst_err_inp,
    output logic [DSZ-1:0] fst_err_dat,
    output logic [DSZ-1:0] o_cnt_rx
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    logic           r_ready;
    logic           r_rq_meta, r_rq_s;
    logic           r_ak_meta, r_ak_s;
    logic           r_rcv_ack;
    logic           r_snd_req;
    logic [DSZ-1:0] r_snd_dat;
    logic [DSZ-1:0] r_cnt;
    state_t         r_state, w_state_nxt;

    logic [DSZ-1:0] r_mem [DEPTH];
    logic [AW:0]    r_wptr, r_rptr;

    logic [ASZ-1:0] w_addr;
    logic [DSZ-1:0] w_dat;
    logic [DSZ-1:0] w_head;
    logic           w_pend, w_inrng, w_full, w_empty;
    logic           w_push, w_pop, w_ack_tgl;

    assign w_addr = rcv0_pakio[PSZ-1:DSZ];
    assign w_dat  = rcv0_pakio[DSZ-1:0];

`ifdef NS_PAKIN_ADDR_CHECK_EN
    logic           w_lo_ok, w_hi_ok;
    logic           r_err;
    logic [ASZ-1:0] r_fst_inp;
    logic [DSZ-1:0] r_fst_dat;

    // Bounds that cover the whole address space collapse to constants.
    if (MIN_ADDR > 0) begin : g_lo_cmp
        assign w_lo_ok = (w_addr >= ASZ'(MIN_ADDR));
    end else begin : g_lo_any
        assign w_lo_ok = 1'b1;
    end
    if (MAX_ADDR < (1 << ASZ) - 1) begin : g_hi_cmp
        assign w_hi_ok = (w_addr <= ASZ'(MAX_ADDR));
    end else begin : g_hi_any
        assign w_hi_ok = 1'b1;
    end
    assign w_inrng = w_lo_ok & w_hi_ok;

    always_ff @(posedge i_clk or negedge reset) begin
        if (!reset) begin
            r_err     <= 1'b0;
            r_fst_inp <= '0;
            r_fst_dat <= '0;
        end else if (w_pend && !w_inrng) begin
            r_err <= 1'b1;
            if (!r_err) begin
                r_fst_inp <= w_addr;
                r_fst_dat <= w_dat;
            end
        end
    end

    assign o_err       = r_err;
    assign fst_err_inp = r_fst_inp;
    assign fst_err_dat = r_fst_dat;
`else
    logic w_unused_addr;
    assign w_unused_addr = ^w_addr;
    assign w_inrng       = 1'b1;
    assign o_err         = 1'b0;
    assign fst_err_inp   = '0;
    assign fst_err_dat   = '0;
`endif

    assign w_pend    = (r_rq_s != r_rcv_ack);
    assign w_push    = w_pend & w_inrng & ~w_full;
    assign w_ack_tgl = w_pend & (~w_inrng | ~w_full);

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_empty = (r_wptr == r_rptr);
    assign w_head  = r_mem[r_rptr[AW-1:0]];

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wptr[AW-1:0]] <= w_dat;
        end
    end

    always_ff @(posedge i_clk or negedge reset) begin
        if (!reset) begin
            r_ready   <= 1'b0;
            r_rq_meta <= 1'b0;
            r_rq_s    <= 1'b0;
            r_ak_meta <= 1'b0;
            r_ak_s    <= 1'b0;
            r_rcv_ack <= 1'b0;
            r_snd_req <= 1'b0;
            r_snd_dat <= '0;
            r_cnt     <= '0;
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_state   <= S_IDLE;
        end else begin
            r_ready   <= 1'b1;
            r_rq_meta <= rcv0_req;
            r_rq_s    <= r_rq_meta;
            r_ak_meta <= snd0_ack;
            r_ak_s    <= r_ak_meta;
            r_state   <= w_state_nxt;
            if (w_ack_tgl) begin
                r_rcv_ack <= ~r_rcv_ack;
            end
            if (w_push) begin
                r_wptr <= r_wptr + (AW+1)'(1);
                r_cnt  <= r_cnt + DSZ'(1);
            end
            if (w_pop) begin
                r_rptr    <= r_rptr + (AW+1)'(1);
                r_snd_dat <= w_head;
                r_snd_req <= ~r_snd_req;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_ak_s == r_snd_req) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign ready     = r_ready;
    assign rcv0_ack  = r_rcv_ack;
    assign snd0_req  = r_snd_req;
    assign snd0_data = r_snd_dat;
    assign o_cnt_rx  = r_cnt;

endmodule
